// File: rtl/obi_pipelined_issue_pkg.sv
// Constants shared by the pipelined OBI issue stage and its credit counter.
package obi_pipelined_issue_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_GNT_CLR
  } obi_issue_fsm_t;

  localparam logic [31:0] OBI_TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/obi_pkg.sv
// Shared OBI channel types: request bundle towards a subordinate and its grant/response bundle.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_issue_credit_cnt.sv
// Saturating up/down count of in-flight OBI transactions; flags responses that arrive with nothing in flight.
module obi_issue_credit_cnt #(
  parameter  int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             avail_o,
  output logic             dec_ok_o,
  output logic             err_o
);

  logic [CNT_W-1:0] count_q;
  logic             err_q;
  logic             inc_ok;
  logic             stray;

  assign avail_o  = (count_q < CNT_W'(MAX_OUTSTANDING));
  assign inc_ok   = inc_i & avail_o;
  assign dec_ok_o = dec_i & (count_q != '0);
  assign stray    = dec_i & (count_q == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case ({inc_ok, dec_ok_o})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (stray) err_q <= 1'b1;
    end
  end

  assign count_o = count_q;
  assign err_o   = err_q;

endmodule

// File: rtl/obi_pipelined_issue.sv
// Holds one master request and re-issues it into the OBI pipeline register until granted.
// Optional response watchdog compiled in with `define OBI_ISSUE_TIMEOUT_EN.
module obi_pipelined_issue
  import obi_pkg::*;
  import obi_pipelined_issue_pkg::*;
#(
  parameter  int unsigned MAX_OUTSTANDING = 2,
  parameter  int unsigned TIMEOUT_CYCLES  = 256,
  localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  obi_req_t         mst_req_i,
  output obi_resp_t        mst_resp_o,
  output obi_req_t         pipe_req_o,
  input  obi_resp_t        pipe_resp_i,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             err_o,
  output logic             timeout_o
);

  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("obi_pipelined_issue: parameter out of range");
  end

  obi_issue_fsm_t state_q, state_d;

  logic        hold_we;
  logic [3:0]  hold_be;
  logic [31:0] hold_addr;
  logic [31:0] hold_wdata;

  logic credit_avail;
  logic mst_gnt;
  logic mst_hs;
  logic rsp_valid;
  logic timeout_fire;

  assign mst_gnt = mst_req_i.req & (state_q == IDLE) & credit_avail;
  assign mst_hs  = mst_gnt;

  obi_issue_credit_cnt #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) i_credit_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .inc_i    (mst_hs),
    .dec_i    (pipe_resp_i.rvalid | timeout_fire),
    .count_o  (outstanding_o),
    .avail_o  (credit_avail),
    .dec_ok_o (rsp_valid),
    .err_o    (err_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (mst_hs) state_d = ISSUE;
      ISSUE: begin
        if (timeout_fire)         state_d = IDLE;
        else if (pipe_resp_i.gnt) state_d = WAIT_GNT_CLR;
      end
      WAIT_GNT_CLR: state_d = mst_hs ? ISSUE : IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // NOTE: holding data is reset too, because pipe_req_o exposes it even while req is low.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hold_we    <= 1'b0;
      hold_be    <= '0;
      hold_addr  <= '0;
      hold_wdata <= '0;
    end else if (mst_hs) begin
      hold_we    <= mst_req_i.we;
      hold_be    <= mst_req_i.be;
      hold_addr  <= mst_req_i.addr;
      hold_wdata <= mst_req_i.wdata;
    end
  end

  // req drops in WAIT_GNT_CLR: the stage's registered gnt lags, so re-asserting would double-issue.
  always_comb begin
    pipe_req_o       = '0;
    pipe_req_o.req   = (state_q == ISSUE);
    pipe_req_o.we    = hold_we & (state_q == ISSUE);
    pipe_req_o.be    = hold_be;
    pipe_req_o.addr  = hold_addr;
    pipe_req_o.wdata = hold_wdata;

    mst_resp_o        = '0;
    mst_resp_o.gnt    = mst_gnt;
    mst_resp_o.rvalid = rsp_valid;
    mst_resp_o.rdata  = timeout_fire ? OBI_TIMEOUT_RDATA : pipe_resp_i.rdata;
  end

`ifdef OBI_ISSUE_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q;

  assign timeout_fire = (outstanding_o != '0) & ~pipe_resp_i.rvalid
                      & (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wd_q <= '0;
    end else if (pipe_resp_i.rvalid || timeout_fire || (outstanding_o == '0)) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WD_W'(1);
    end
  end

  assign timeout_o = timeout_fire;
`else
  assign timeout_fire = 1'b0;
  assign timeout_o    = 1'b0;
`endif

endmodule

// File: tb/tb_obi_pipelined_issue.sv
// Bench for obi_pipelined_issue: transaction-level model checked every cycle plus directed literal checks.
module tb_obi_pipelined_issue;
  import obi_pkg::*;

  localparam int MAX = 2;
  localparam int TMO = 8;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  obi_req_t   mst_req;
  obi_resp_t  mst_resp;
  obi_req_t   pipe_req;
  obi_resp_t  pipe_resp;
  logic [1:0] outstanding;
  logic       err;
  logic       timeout;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clk_i = ~clk_i;

  obi_pipelined_issue #(
    .MAX_OUTSTANDING (MAX),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .mst_req_i     (mst_req),
    .mst_resp_o    (mst_resp),
    .pipe_req_o    (pipe_req),
    .pipe_resp_i   (pipe_resp),
    .outstanding_o (outstanding),
    .err_o         (err),
    .timeout_o     (timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted request is "pending" until the stage grants it,
  // the cycle after a grant is a cool-down, and responses retire in-flight credits.
  int          m_inflight, m_idle;
  bit          m_pending, m_cool, m_err;
  bit          m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  bit          u_hs, u_tmo, u_rv;

  function automatic bit exp_gnt();
    return mst_req.req && !m_pending && !m_cool && (m_inflight < MAX);
  endfunction

  function automatic bit exp_tmo();
`ifdef OBI_ISSUE_TIMEOUT_EN
    return (m_inflight > 0) && !pipe_resp.rvalid && (m_idle + 1 == TMO);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      m_inflight = 0; m_idle = 0; m_pending = 0; m_cool = 0; m_err = 0;
      m_we = 0; m_be = '0; m_addr = '0; m_wdata = '0;
    end else begin
      u_hs  = exp_gnt();
      u_tmo = exp_tmo();
      u_rv  = pipe_resp.rvalid;
      m_idle = (m_inflight > 0 && !u_rv && !u_tmo) ? m_idle + 1 : 0;
      m_cool = m_pending && pipe_resp.gnt && !u_tmo;
      if (m_pending && (pipe_resp.gnt || u_tmo)) m_pending = 0;
      if (u_hs) begin
        m_pending = 1;
        m_we = mst_req.we; m_be = mst_req.be; m_addr = mst_req.addr; m_wdata = mst_req.wdata;
      end
      if (u_rv && m_inflight == 0) m_err = 1;
      m_inflight = m_inflight + int'(u_hs) - int'((u_rv || u_tmo) && m_inflight > 0);
    end
  end

  bit c_rv, c_tmo;
  always @(negedge clk_i) begin
    if (chk_on) begin
      c_tmo = exp_tmo();
      c_rv  = (pipe_resp.rvalid && m_inflight > 0) || c_tmo;
      check("m_gnt",    32'(mst_resp.gnt),    32'(exp_gnt()));
      check("m_rvalid", 32'(mst_resp.rvalid), 32'(c_rv));
      if (c_rv) check("m_rdata", mst_resp.rdata, c_tmo ? 32'hDEAD_BEEF : pipe_resp.rdata);
      check("m_pipe_req",   32'(pipe_req.req),  32'(m_pending));
      check("m_pipe_we",    32'(pipe_req.we),   32'(m_pending && m_we));
      check("m_pipe_be",    32'(pipe_req.be),   32'(m_be));
      check("m_pipe_addr",  pipe_req.addr,      m_addr);
      check("m_pipe_wdata", pipe_req.wdata,     m_wdata);
      check("m_outstanding", 32'(outstanding),  m_inflight);
      check("m_err",         32'(err),          32'(m_err));
      check("m_timeout",     32'(timeout),      32'(c_tmo));
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got still running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    bit seen;
    rst_ni = 1'b0; mst_req = '0; pipe_resp = '0;
    tick(); chk_on = 1'b1; tick();
    rst_ni = 1'b1; #1;
    check("rst_outstanding", 32'(outstanding), 0);
    check("rst_err",         32'(err), 0);
    check("rst_pipe_req",    32'(pipe_req.req), 0);
    check("rst_pipe_addr",   pipe_req.addr, 0);

    // Single read
    mst_req.req = 1; mst_req.addr = 32'h100; #1;
    check("rd_gnt", 32'(mst_resp.gnt), 1);
    tick(); mst_req = '0; #1;
    check("rd_issue_req",  32'(pipe_req.req), 1);
    check("rd_issue_addr", pipe_req.addr, 32'h100);
    check("rd_out1",       32'(outstanding), 1);
    tick(); pipe_resp.gnt = 1; #1;
    check("rd_req_at_gnt", 32'(pipe_req.req), 1);
    tick(); pipe_resp.gnt = 0; #1;
    check("rd_req_c3", 32'(pipe_req.req), 0);
    tick(); #1;
    check("rd_req_c4", 32'(pipe_req.req), 0);
    pipe_resp.rvalid = 1; pipe_resp.rdata = 32'hCAFE; #1;
    check("rd_rvalid", 32'(mst_resp.rvalid), 1);
    check("rd_rdata",  mst_resp.rdata, 32'hCAFE);
    tick(); pipe_resp = '0; #1;
    check("rd_out0", 32'(outstanding), 0);

    // Credit cap with responses withheld
    mst_req.req = 1; mst_req.addr = 32'h200; #1;
    check("cap_gnt_a", 32'(mst_resp.gnt), 1);
    tick(); mst_req = '0; pipe_resp.gnt = 1;
    tick(); pipe_resp.gnt = 0;
    tick(); mst_req.req = 1; mst_req.addr = 32'h204; #1;
    check("cap_gnt_b", 32'(mst_resp.gnt), 1);
    tick(); mst_req = '0; pipe_resp.gnt = 1;
    tick(); pipe_resp.gnt = 0;
    tick(); mst_req.req = 1; mst_req.addr = 32'h208; #1;
    check("cap_gnt_blocked", 32'(mst_resp.gnt), 0);
    check("cap_out2",        32'(outstanding), 2);
    tick(); #1;
    check("cap_gnt_blocked2", 32'(mst_resp.gnt), 0);
    tick(); pipe_resp.rvalid = 1; pipe_resp.rdata = 32'h11; #1;
    check("cap_gnt_at_rvalid", 32'(mst_resp.gnt), 0);
    check("cap_rvalid",        32'(mst_resp.rvalid), 1);
    tick(); pipe_resp = '0; #1;
    check("cap_gnt_after", 32'(mst_resp.gnt), 1);
    check("cap_out1",      32'(outstanding), 1);
    tick(); mst_req = '0; pipe_resp.gnt = 1; #1;
    check("cap_out2b", 32'(outstanding), 2);
    tick(); pipe_resp.gnt = 0;
    tick(); pipe_resp.rvalid = 1; pipe_resp.rdata = 32'h22;
    tick(); pipe_resp = '0; #1;
    check("cap_out_drain", 32'(outstanding), 1);

    // Handshake and response in the same cycle at count 1
    mst_req.req = 1; mst_req.addr = 32'h20C;
    pipe_resp.rvalid = 1; pipe_resp.rdata = 32'h33; #1;
    check("sim_gnt",    32'(mst_resp.gnt), 1);
    check("sim_rvalid", 32'(mst_resp.rvalid), 1);
    tick(); mst_req = '0; pipe_resp = '0; pipe_resp.gnt = 1; #1;
    check("sim_out", 32'(outstanding), 1);
    tick(); pipe_resp.gnt = 0;
    tick(); pipe_resp.rvalid = 1; pipe_resp.rdata = 32'h44;
    tick(); pipe_resp = '0; #1;
    check("sim_out0", 32'(outstanding), 0);

    // Write held through a stalled grant
    mst_req.req = 1; mst_req.we = 1; mst_req.addr = 32'h300;
    mst_req.wdata = 32'h1234; mst_req.be = 4'hF; #1;
    check("wr_gnt", 32'(mst_resp.gnt), 1);
    tick(); mst_req = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("wr_stall_req",   32'(pipe_req.req), 1);
      check("wr_stall_we",    32'(pipe_req.we), 1);
      check("wr_stall_wdata", pipe_req.wdata, 32'h1234);
      check("wr_stall_addr",  pipe_req.addr, 32'h300);
      check("wr_stall_be",    32'(pipe_req.be), 32'hF);
      tick();
    end
    pipe_resp.gnt = 1; #1;
    check("wr_req_at_gnt", 32'(pipe_req.req), 1);
    tick(); pipe_resp.gnt = 0; #1;
    check("wr_no_dup_req", 32'(pipe_req.req), 0);
    check("wr_we_low",     32'(pipe_req.we), 0);
    check("wr_wdata_hold", pipe_req.wdata, 32'h1234);
    tick(); #1;
    check("wr_idle_req", 32'(pipe_req.req), 0);
    pipe_resp.rvalid = 1;
    tick(); pipe_resp = '0; #1;
    check("wr_out0", 32'(outstanding), 0);

    // Stray response, sticky error, cleared by reset
    pipe_resp.rvalid = 1; pipe_resp.rdata = 32'h55; #1;
    check("stray_no_fwd", 32'(mst_resp.rvalid), 0);
    tick(); pipe_resp = '0; #1;
    check("stray_err", 32'(err), 1);
    tick(); tick(); #1;
    check("stray_err_held", 32'(err), 1);
    rst_ni = 0; tick(); rst_ni = 1; #1;
    check("stray_err_clr", 32'(err), 0);

    // Reset while a request sits in ISSUE; late response becomes a stray
    mst_req.req = 1; mst_req.we = 1; mst_req.addr = 32'h500; mst_req.wdata = 32'h99;
    tick(); mst_req = '0; #1;
    check("rmid_req", 32'(pipe_req.req), 1);
    rst_ni = 0; tick(); rst_ni = 1; #1;
    check("rmid_req0",  32'(pipe_req.req), 0);
    check("rmid_addr0", pipe_req.addr, 0);
    check("rmid_out0",  32'(outstanding), 0);
    pipe_resp.rvalid = 1; #1;
    check("rmid_no_fwd", 32'(mst_resp.rvalid), 0);
    tick(); pipe_resp = '0; #1;
    check("rmid_err", 32'(err), 1);
    rst_ni = 0; tick(); rst_ni = 1;

`ifdef OBI_ISSUE_TIMEOUT_EN
    // Read never answered: watchdog completes it on the 8th waiting cycle
    mst_req.req = 1; mst_req.addr = 32'h400; #1;
    check("tmo_gnt", 32'(mst_resp.gnt), 1);
    tick(); mst_req = '0; pipe_resp.gnt = 1;
    tick(); pipe_resp.gnt = 0;
    seen = 0;
    for (int k = 2; k <= 20 && !seen; k++) begin
      #1;
      if (mst_resp.rvalid) begin
        seen = 1;
        check("tmo_cycle", k, TMO);
        check("tmo_rdata", mst_resp.rdata, 32'hDEAD_BEEF);
        check("tmo_pulse", 32'(timeout), 1);
      end
      tick();
    end
    if (!seen) check("tmo_seen", 0, 1);
    #1;
    check("tmo_pulse_end", 32'(timeout), 0);
    check("tmo_out0",      32'(outstanding), 0);
    pipe_resp.rvalid = 1; #1;
    check("tmo_late_no_fwd", 32'(mst_resp.rvalid), 0);
    tick(); pipe_resp = '0; #1;
    check("tmo_late_err", 32'(err), 1);
`else
    seen = 0;
    check("tmo_off", 32'(timeout), 32'(seen));
`endif

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
